gpio_ctrl: RTL and testbench
============================

# gpio_ctrl

Parametrised GPIO controller with a register interface for the core's peripheral bus, per-pin direction and output, synchronised inputs, atomic set/clear/toggle, and edge-triggered interrupts. It sits between the core's peripheral bus and the pad-level tri-state buffers. It generalises the fixed 8-pin direction/value GPIO to N_PINS pins, with interrupt generation that the earlier block lacks.

## Interface
- N_PINS, 8, number of GPIO pins; legal range 1..32.
- SYNC_STAGES, 2, flip-flop stages on each input pin; legal range 2..4.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  1  bus request; each cycle it is high is one transaction.
- we_i  in  1  1 = write, 0 = read; qualified by req_i.
- addr_i  in  6  byte address; bits [1:0] ignored.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data; valid while ack_o is high.
- ack_o  out  1  transaction acknowledge, one cycle after req_i.
- gpio_oe_o  out  N_PINS  1 = pin driven by gpio_out_o; 0 = pin is an input (high-Z).
- gpio_out_o  out  N_PINS  output values.
- gpio_in_i  in  N_PINS  raw pad input values; asynchronous to clk.
- irq_o  out  1  level interrupt; high while any pending bit is set.

## Operation
- Register map:
  - 0x00 DIR (RW): drives gpio_oe_o.
  - 0x04 OUT (RW): drives gpio_out_o.
  - 0x08 IN (RO): synchronised inputs.
  - 0x0C SET (WO): OUT |= wdata.
  - 0x10 CLR (WO): OUT &= ~wdata.
  - 0x14 TGL (WO): OUT ^= wdata.
  - 0x18 RISE_EN (RW).
  - 0x1C FALL_EN (RW).
  - 0x20 PENDING (RW1C).
- Width rules:
  - Only bits [N_PINS-1:0] exist.
  - Write data above N_PINS is ignored.
  - Reads return 0 above N_PINS.
- SET, CLR and TGL read as 0.
- Unmapped addresses (0x24..0x3C): reads return 0, writes are ignored, ack_o still asserts.
- Input path:
  - Each pin passes through SYNC_STAGES flops to give sync[i].
  - A further flop holds prev[i].
  - Rising edge = sync & ~prev; falling edge = ~sync & prev.
- Pending bit i sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- A PENDING write clears the bits written as 1.
- If a set and a clear of the same bit occur in the same cycle, the set wins and the bit stays 1.
- Clearing RISE_EN or FALL_EN does not clear PENDING.
- irq_o = OR of PENDING, driven combinationally from the PENDING register.
- IN reflects sync regardless of DIR; an output pin reads back its pad value.
- Reset values:
  - DIR, OUT, RISE_EN, FALL_EN, PENDING all 0, so gpio_oe_o = 0 (all inputs), gpio_out_o = 0, irq_o = 0.
  - Synchroniser and prev flops 0; rdata_o = 0; ack_o = 0.
- Reset mid-transaction: the transaction is dropped and no ack_o follows.
- No edge can set PENDING after reset until an EN register is written.

## Timing
- Bus:
  - Request sampled at edge t.
  - ack_o is high for exactly one cycle after t, with registered rdata_o.
  - Back-to-back requests on consecutive cycles are each acknowledged on consecutive cycles.
  - No wait states.
- Write visibility:
  - The register updates at edge t.
  - gpio_oe_o and gpio_out_o change one cycle after the request.
  - A read in the next cycle returns the new value.
- Input latency:
  - A pad change stable before edge t appears in IN / sync after SYNC_STAGES edges.
  - PENDING and irq_o assert one edge later, i.e. SYNC_STAGES+1 cycles after the pad change.
- A PENDING clear takes effect at the write edge; irq_o falls in the following cycle if no bits remain set.

## Test plan
- Reset: assert rst_i asynchronously mid-cycle → gpio_oe_o = 0, gpio_out_o = 0, irq_o = 0, ack_o = 0 immediately.
- Atomic ops, N_PINS = 8:
  - Write OUT = 0x0F, SET 0xF0, CLR 0x03, TGL 0x81.
  - Read OUT → 0x7D; gpio_out_o = 0x7D.
  - Writing OUT = 0xFFFF_FF00 reads back 0x00.
- Input sync, SYNC_STAGES = 2: drive gpio_in_i 0x00 → 0xA5 → IN reads 0xA5 no earlier than 2 cycles later; intermediate reads return 0x00.
- Edge interrupts:
  - RISE_EN = 0x01, FALL_EN = 0x02.
  - Pin 0 rises → PENDING = 0x01, irq_o = 1 at cycle 3.
  - Pin 1 falls → PENDING = 0x03.
  - Pin 0 falls → no change.
  - Write PENDING = 0x01 → 0x02; write 0x02 → irq_o = 0.
- Collision: clear PENDING bit 0 in the same cycle a new enabled rising edge on pin 0 is detected → PENDING bit 0 remains 1, irq_o stays 1.
- Bus: reads of 0x24 and 0x3C on back-to-back cycles → two ack_o pulses, rdata_o = 0; read of SET → 0.

Source files
------------

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: N_PINS-wide GPIO controller with a single-cycle register bus,
// per-pin direction/output, atomic SET/CLR/TGL, input synchronisers and
// edge-triggered, sticky interrupt pending bits.
module gpio_ctrl #(
    parameter int N_PINS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [5:0]        addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ack_o,
    output logic [N_PINS-1:0] gpio_oe_o,
    output logic [N_PINS-1:0] gpio_out_o,
    input  logic [N_PINS-1:0] gpio_in_i,
    output logic              irq_o
);

    // Word index (addr_i[5:2]) of each register.
    localparam logic [3:0] A_DIR  = 4'd0;
    localparam logic [3:0] A_OUT  = 4'd1;
    localparam logic [3:0] A_IN   = 4'd2;
    localparam logic [3:0] A_SET  = 4'd3;
    localparam logic [3:0] A_CLR  = 4'd4;
    localparam logic [3:0] A_TGL  = 4'd5;
    localparam logic [3:0] A_RISE = 4'd6;
    localparam logic [3:0] A_FALL = 4'd7;
    localparam logic [3:0] A_PEND = 4'd8;

    localparam logic [N_PINS-1:0] ZERO_PINS = {N_PINS{1'b0}};

    logic [N_PINS-1:0] dir_r;
    logic [N_PINS-1:0] out_r;
    logic [N_PINS-1:0] rise_en_r;
    logic [N_PINS-1:0] fall_en_r;
    logic [N_PINS-1:0] pending_r;
    logic [N_PINS-1:0] prev_r;
    logic [N_PINS-1:0] sync_r [SYNC_STAGES];
    logic [31:0]       rdata_r;
    logic              ack_r;

    logic [3:0]        word_s;
    logic              wr_s;
    logic              rd_en_s;
    logic [N_PINS-1:0] wmask_s;
    logic [N_PINS-1:0] sync_s;
    logic [N_PINS-1:0] rise_s;
    logic [N_PINS-1:0] fall_s;
    logic [N_PINS-1:0] set_s;
    logic [N_PINS-1:0] clr_s;
    logic [N_PINS-1:0] dir_nxt_s;
    logic [N_PINS-1:0] out_nxt_s;
    logic [N_PINS-1:0] rise_en_nxt_s;
    logic [N_PINS-1:0] fall_en_nxt_s;
    logic [N_PINS-1:0] pending_nxt_s;
    logic [31:0]       rd_s;
    logic              unused_s;

    assign word_s  = addr_i[5:2];
    assign wr_s    = req_i & we_i;
    assign rd_en_s = req_i & ~we_i;
    assign wmask_s = wdata_i[N_PINS-1:0];
    assign sync_s  = sync_r[SYNC_STAGES-1];
    assign rise_s  = sync_s & ~prev_r;
    assign fall_s  = ~sync_s & prev_r;
    assign set_s   = (rise_s & rise_en_r) | (fall_s & fall_en_r);

    // Byte-lane bits of the address and write data above N_PINS carry no meaning.
    assign unused_s = ^{addr_i[1:0], wdata_i};

    // Input synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= ZERO_PINS;
            end
            prev_r <= ZERO_PINS;
        end else begin
            sync_r[0] <= gpio_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= sync_s;
        end
    end

    // Next value of every writable register, including the atomic OUT ops.
    always_comb begin
        dir_nxt_s     = dir_r;
        out_nxt_s     = out_r;
        rise_en_nxt_s = rise_en_r;
        fall_en_nxt_s = fall_en_r;
        clr_s         = ZERO_PINS;
        if (wr_s) begin
            case (word_s)
                A_DIR:   dir_nxt_s     = wmask_s;
                A_OUT:   out_nxt_s     = wmask_s;
                A_SET:   out_nxt_s     = out_r | wmask_s;
                A_CLR:   out_nxt_s     = out_r & ~wmask_s;
                A_TGL:   out_nxt_s     = out_r ^ wmask_s;
                A_RISE:  rise_en_nxt_s = wmask_s;
                A_FALL:  fall_en_nxt_s = wmask_s;
                A_PEND:  clr_s         = wmask_s;
                default: clr_s         = ZERO_PINS;
            endcase
        end else begin
            clr_s = ZERO_PINS;
        end
        // A new edge in the same cycle as a clear wins.
        pending_nxt_s = (pending_r & ~clr_s) | set_s;
    end

    // Read multiplexer; unimplemented bits and write-only/unmapped words read 0.
    always_comb begin
        rd_s = 32'd0;
        case (word_s)
            A_DIR:   rd_s[N_PINS-1:0] = dir_r;
            A_OUT:   rd_s[N_PINS-1:0] = out_r;
            A_IN:    rd_s[N_PINS-1:0] = sync_s;
            A_RISE:  rd_s[N_PINS-1:0] = rise_en_r;
            A_FALL:  rd_s[N_PINS-1:0] = fall_en_r;
            A_PEND:  rd_s[N_PINS-1:0] = pending_r;
            default: rd_s = 32'd0;
        endcase
    end

    // Control/status register file.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            dir_r     <= ZERO_PINS;
            out_r     <= ZERO_PINS;
            rise_en_r <= ZERO_PINS;
            fall_en_r <= ZERO_PINS;
            pending_r <= ZERO_PINS;
        end else begin
            dir_r     <= dir_nxt_s;
            out_r     <= out_nxt_s;
            rise_en_r <= rise_en_nxt_s;
            fall_en_r <= fall_en_nxt_s;
            pending_r <= pending_nxt_s;
        end
    end

    // Bus response: one-cycle ack with registered read data.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            ack_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            ack_r   <= req_i;
            rdata_r <= rd_en_s ? rd_s : 32'd0;
        end
    end

    assign ack_o      = ack_r;
    assign rdata_o    = rdata_r;
    assign gpio_oe_o  = dir_r;
    assign gpio_out_o = out_r;
    assign irq_o      = |pending_r;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed plus randomized bus/pad stimulus against a
// delay-line reference model of the GPIO controller.
module tb_gpio_ctrl;

    localparam int N = 8;
    localparam int S = 2;

    logic        clk;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [5:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic [N-1:0] gpio_oe_o;
    logic [N-1:0] gpio_out_o;
    logic [N-1:0] gpio_in_i;
    logic        irq_o;

    gpio_ctrl #(.N_PINS(N), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .ack_o      (ack_o),
        .gpio_oe_o  (gpio_oe_o),
        .gpio_out_o (gpio_out_o),
        .gpio_in_i  (gpio_in_i),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: register values plus a history of pad samples,
    // hist[0] being the pad value sampled at the most recent edge.
    logic [7:0]  m_dir, m_out, m_rise, m_fall, m_pend;
    logic [7:0]  hist [0:S];
    logic [31:0] m_rdata;
    logic        m_ack;
    logic [7:0]  cur_pad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dir = 8'h00; m_out = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_pend = 8'h00;
        m_rdata = 32'd0; m_ack = 1'b0;
        for (int i = 0; i <= S; i++) hist[i] = 8'h00;
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_edge(input logic req, input logic we, input logic [5:0] addr,
                              input logic [31:0] wd, input logic [7:0] pad);
        logic [7:0] sy, pv, evt, w;
        sy  = hist[S-1];          // synchronised value: pad S samples back
        pv  = hist[S];            // one sample older
        evt = ((sy & ~pv) & m_rise) | ((~sy & pv) & m_fall);
        w   = wd[7:0];
        m_ack   = req;
        m_rdata = 32'd0;
        if (req && !we) begin
            case (addr[5:2])
                4'd0: m_rdata = {24'd0, m_dir};
                4'd1: m_rdata = {24'd0, m_out};
                4'd2: m_rdata = {24'd0, sy};
                4'd6: m_rdata = {24'd0, m_rise};
                4'd7: m_rdata = {24'd0, m_fall};
                4'd8: m_rdata = {24'd0, m_pend};
                default: m_rdata = 32'd0;
            endcase
        end
        if (req && we) begin
            case (addr[5:2])
                4'd0: m_dir  = w;
                4'd1: m_out  = w;
                4'd3: m_out  = m_out | w;
                4'd4: m_out  = m_out & ~w;
                4'd5: m_out  = m_out ^ w;
                4'd6: m_rise = w;
                4'd7: m_fall = w;
                4'd8: m_pend = m_pend & ~w;
                default: ;
            endcase
        end
        m_pend = m_pend | evt;
        for (int i = S; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pad;
    endtask

    task automatic tick(input logic req, input logic we, input logic [5:0] addr,
                        input logic [31:0] wd, input string tag);
        req_i = req; we_i = we; addr_i = addr; wdata_i = wd; gpio_in_i = cur_pad;
        @(posedge clk);
        model_edge(req, we, addr, wd, cur_pad);
        #1;
        chk({tag, ".ack"}, {31'd0, ack_o}, {31'd0, m_ack});
        if (req && !we) chk({tag, ".rdata"}, rdata_o, m_rdata);
        chk({tag, ".oe"},  {24'd0, gpio_oe_o},  {24'd0, m_dir});
        chk({tag, ".out"}, {24'd0, gpio_out_o}, {24'd0, m_out});
        chk({tag, ".irq"}, {31'd0, irq_o},      {31'd0, |m_pend});
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input string tag);
        tick(1'b1, 1'b1, a, d, tag);
    endtask

    task automatic rd(input logic [5:0] a, input string tag);
        tick(1'b1, 1'b0, a, 32'd0, tag);
    endtask

    task automatic idle(input string tag);
        tick(1'b0, 1'b0, 6'd0, 32'd0, tag);
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 6'd0; wdata_i = 32'd0;
        cur_pad = 8'h00; gpio_in_i = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;

        // Reset state
        chk("rst.ack",   {31'd0, ack_o}, 32'd0);
        chk("rst.oe",    {24'd0, gpio_oe_o}, 32'd0);
        chk("rst.out",   {24'd0, gpio_out_o}, 32'd0);
        chk("rst.irq",   {31'd0, irq_o}, 32'd0);
        chk("rst.rdata", rdata_o, 32'd0);

        // Atomic set/clear/toggle
        wr(6'h00, 32'h0000_00FF, "dir");
        wr(6'h04, 32'h0000_000F, "out");
        wr(6'h0C, 32'h0000_00F0, "set");
        wr(6'h10, 32'h0000_0003, "clr");
        wr(6'h14, 32'h0000_0081, "tgl");
        rd(6'h04, "rd_out");
        chk("atomic.rdata", rdata_o, 32'h0000_007D);
        chk("atomic.pins", {24'd0, gpio_out_o}, 32'h0000_007D);
        wr(6'h04, 32'hFFFF_FF00, "out_wide");
        rd(6'h04, "rd_out_wide");
        chk("wide.rdata", rdata_o, 32'h0000_0000);

        // Input synchroniser latency
        wr(6'h00, 32'd0, "dir0");
        cur_pad = 8'hA5;
        rd(6'h08, "in_t0");
        chk("in.t0", rdata_o, 32'h0000_0000);
        rd(6'h08, "in_t1");
        chk("in.t1", rdata_o, 32'h0000_0000);
        rd(6'h08, "in_t2");
        chk("in.t2", rdata_o, 32'h0000_00A5);

        // Edge interrupts
        cur_pad = 8'h02;
        repeat (4) idle("settle");
        wr(6'h18, 32'h0000_0001, "rise_en");
        wr(6'h1C, 32'h0000_0002, "fall_en");
        cur_pad = 8'h03;
        idle("r0_c1");
        chk("irq.c1", {31'd0, irq_o}, 32'd0);
        idle("r0_c2");
        chk("irq.c2", {31'd0, irq_o}, 32'd0);
        idle("r0_c3");
        chk("irq.c3", {31'd0, irq_o}, 32'd1);
        rd(6'h20, "pend_a");
        chk("pend.rise0", rdata_o, 32'h0000_0001);
        cur_pad = 8'h01;
        repeat (3) idle("f1");
        rd(6'h20, "pend_b");
        chk("pend.fall1", rdata_o, 32'h0000_0003);
        cur_pad = 8'h00;
        repeat (3) idle("f0");
        rd(6'h20, "pend_c");
        chk("pend.fall0", rdata_o, 32'h0000_0003);
        wr(6'h20, 32'h0000_0001, "w1c_0");
        rd(6'h20, "pend_d");
        chk("pend.w1c0", rdata_o, 32'h0000_0002);
        wr(6'h20, 32'h0000_0002, "w1c_1");
        chk("irq.cleared", {31'd0, irq_o}, 32'd0);

        // Set/clear collision on pin 0
        cur_pad = 8'h01;
        repeat (3) idle("col_a");
        cur_pad = 8'h00;
        repeat (3) idle("col_b");
        cur_pad = 8'h01;
        idle("col_c1");
        idle("col_c2");
        wr(6'h20, 32'h0000_0001, "col_clr");
        chk("col.irq", {31'd0, irq_o}, 32'd1);
        rd(6'h20, "col_rd");
        chk("col.pend", rdata_o, 32'h0000_0001);

        // Unmapped and write-only reads, back to back
        rd(6'h24, "unm24");
        chk("unm24.rdata", rdata_o, 32'd0);
        rd(6'h3C, "unm3c");
        chk("unm3c.rdata", rdata_o, 32'd0);
        rd(6'h0C, "rd_set");
        chk("set.rdata", rdata_o, 32'd0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) cur_pad = 8'($urandom);
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 63)), $urandom, "rnd");
        end

        // Asynchronous reset in the middle of a cycle with a live transaction
        wr(6'h00, 32'h0000_00FF, "pre_dir");
        wr(6'h04, 32'h0000_00AA, "pre_out");
        wr(6'h18, 32'h0000_00FF, "pre_rise");
        rd(6'h00, "pre_rd");
        req_i = 1'b1; we_i = 1'b0; addr_i = 6'h04;
        #2 rst_i = 1'b1;
        #1;
        chk("arst.oe",  {24'd0, gpio_oe_o}, 32'd0);
        chk("arst.out", {24'd0, gpio_out_o}, 32'd0);
        chk("arst.irq", {31'd0, irq_o}, 32'd0);
        chk("arst.ack", {31'd0, ack_o}, 32'd0);
        model_reset();
        cur_pad = 8'h00; gpio_in_i = 8'h00;
        @(posedge clk);
        #1;
        chk("arst.noack", {31'd0, ack_o}, 32'd0);
        req_i = 1'b0;
        rst_i = 1'b0;

        // No edge may pend before an enable register is written
        for (int k = 0; k < 20; k++) begin
            cur_pad = 8'($urandom);
            idle("post_rst");
        end
        rd(6'h20, "post_pend");
        chk("post.pend", rdata_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
